timer_controller: RTL

//  Sequencer on the consuming end of the 2 s timer handshake. Drives the timer's enable and reset,

---
 rtl/timer_ctrl_if.sv | 27 ++
 rtl/timer_controller.sv | 126 ++++++++++++
 2 files changed

// File: rtl/timer_ctrl_if.sv
// Control/timer handshake bundle between top-level control, the phase sequencer and its timer.
// Pure wiring, no latency; the sequencer's only backpressure is the timer's sticky done.
// master = control/timer side, slave = sequencer side.
interface timer_ctrl_if #(
    parameter int PHASE_W = 2
);
    logic               start;
    logic               abort;
    logic               timer_done;
    logic               timer_enable;
    logic               timer_clear;
    logic [PHASE_W-1:0] phase;
    logic               phase_start;
    logic               busy;
    logic               seq_done;
    logic               aborted;

    modport master (
        output start, abort, timer_done,
        input  timer_enable, timer_clear, phase, phase_start, busy, seq_done, aborted
    );

    modport slave (
        input  start, abort, timer_done,
        output timer_enable, timer_clear, phase, phase_start, busy, seq_done, aborted
    );
endinterface

// File: rtl/timer_controller.sv
// Steps through NUM_PHASES timed phases, each one clear/enable/done cycle of an external timer.
// Latency: start -> CLEAR next cycle, enable the cycle after; done -> next enable 3 cycles later.
// Backpressure: each phase waits on timer_done; abort preempts everything, start ignored while busy.
module timer_controller #(
    parameter int NUM_PHASES = 4,
    parameter int PHASE_W    = 2,
    parameter bit LOOP       = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    timer_ctrl_if.slave  ctl
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    if (NUM_PHASES < 2 || PHASE_W < $clog2(NUM_PHASES)) begin : g_param_check
        $error("timer_controller: NUM_PHASES must be >= 2 and fit in PHASE_W bits");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_ADVANCE = 3'd3,
        S_FINISH  = 3'd4,
        S_ABORT   = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_nxt;

    logic timer_enable_q;
    logic timer_clear_q;
    logic phase_start_q;
    logic busy_q;
    logic seq_done_q;
    logic aborted_q;

    always_comb begin
        state_nxt = state_q;
        phase_nxt = phase_q;
        case (state_q)
            S_IDLE: begin
                // abort wins over start here and produces no aborted pulse
                if (ctl.start && !ctl.abort) begin
                    state_nxt = S_CLEAR;
                    phase_nxt = '0;
                end
            end
            S_CLEAR: begin
                state_nxt = ctl.abort ? S_ABORT : S_RUN;
            end
            S_RUN: begin
                if (ctl.abort) begin
                    state_nxt = S_ABORT;
                end else if (ctl.timer_done) begin
                    state_nxt = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (ctl.abort) begin
                    state_nxt = S_ABORT;
                end else if (phase_q != LAST_PHASE) begin
                    state_nxt = S_CLEAR;
                    phase_nxt = phase_q + PHASE_W'(1);
                end else if (LOOP) begin
                    state_nxt = S_CLEAR;
                    phase_nxt = '0;
                end else begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                state_nxt = ctl.abort ? S_ABORT : S_IDLE;
            end
            S_ABORT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                phase_nxt = '0;
            end
        endcase
        // phase reads 0 during the ABORT cycle itself
        if (state_nxt == S_ABORT) begin
            phase_nxt = '0;
        end
    end

    // Outputs are registered from the next state so they line up with state_q without any
    // input-to-output combinational path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            phase_q        <= '0;
            timer_enable_q <= 1'b0;
            timer_clear_q  <= 1'b0;
            phase_start_q  <= 1'b0;
            busy_q         <= 1'b0;
            seq_done_q     <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            phase_q        <= phase_nxt;
            timer_enable_q <= (state_nxt == S_RUN);
            timer_clear_q  <= (state_nxt == S_CLEAR) || (state_nxt == S_FINISH) ||
                              (state_nxt == S_ABORT);
            phase_start_q  <= (state_nxt == S_CLEAR);
            busy_q         <= (state_nxt != S_IDLE);
            seq_done_q     <= (state_nxt == S_FINISH) ||
                              (LOOP && (state_nxt == S_ADVANCE) && (phase_nxt == LAST_PHASE));
            aborted_q      <= (state_nxt == S_ABORT);
        end
    end

    assign ctl.timer_enable = timer_enable_q;
    assign ctl.timer_clear  = timer_clear_q;
    assign ctl.phase        = phase_q;
    assign ctl.phase_start  = phase_start_q;
    assign ctl.busy         = busy_q;
    assign ctl.seq_done     = seq_done_q;
    assign ctl.aborted      = aborted_q;

endmodule
